seven_segment_reader: RTL and testbench

SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

---
 rtl/seven_seg_pkg.sv | 29 ++
 rtl/seg_pattern_to_nibble.sv | 30 +++
 rtl/seven_segment_reader.sv | 128 ++++++++++++
 tb/tb_seven_segment_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared constants for the seven-segment reader: active-low
//               hex pattern table, blank pattern, digit count, default dwell.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS            = 4;
  localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

  // All segments dark (active-low bus)
  localparam logic [6:0] BLANK = 7'h7F;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_pattern_t;

  // Entry n holds the active-low pattern (bit0=a .. bit6=g) that shows hex digit n
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h18, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage
`default_nettype wire

// File: rtl/seg_pattern_to_nibble.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seg_pattern_to_nibble
// Description : Combinational decode of a 7-bit active-low segment pattern
//               to a hex nibble; unknown patterns give 0 with invalid set.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_pattern_to_nibble
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       invalid_o
);

  // Table search; patterns are unique, so at most one entry matches
  always_comb begin
    nibble_o  = '0;
    invalid_o = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == SEG_TABLE[i]) begin
        nibble_o  = 4'(i);
        invalid_o = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seven_segment_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seven_segment_reader
// Description : Recovers a 4-digit hex word from a multiplexed active-low
//               seven-segment bus. Each digit must dwell STABLE_CYCLES
//               registered samples before capture; the full word is offered
//               with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_reader
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  input  logic        out_ready,
  output logic [15:0] value,
  output logic [3:0]  err,
  output logic        out_valid,
  output logic [3:0]  digit_seen
);

  // Counter saturates here; capture fires on the edge that reaches it
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [3:0]  sel_q, sel_prev_q;
  logic [6:0]  seg_q, seg_prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  seen_q, seen_d;
  logic        valid_q, valid_d;

  logic        pair_stable;
  logic        pair_onehot;
  logic        capture;
  logic [3:0]  dec_nibble;
  logic        dec_invalid;

  seg_pattern_to_nibble u_decode (
    .pattern_i (seg_q),
    .nibble_o  (dec_nibble),
    .invalid_o (dec_invalid)
  );

  assign pair_stable = (sel_q == sel_prev_q) && (seg_q == seg_prev_q);
  assign pair_onehot = $onehot(sel_q);
  // Counter is one short of its final value, so this edge completes the dwell
  assign capture     = pair_stable && pair_onehot && (cnt_q == CNT_LAST - 8'd1);

  // Stability counter: clears on any change or non-one-hot strobe, saturates at the end
  always_comb begin
    cnt_d = cnt_q;
    if (!pair_stable || !pair_onehot) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Word assembly and handshake; a pending word freezes all capture state
  always_comb begin
    value_d = value_q;
    err_d   = err_q;
    seen_d  = seen_q;
    valid_d = valid_q;
    if (valid_q) begin
      if (out_ready) begin
        seen_d  = '0;
        valid_d = 1'b0;
      end
    end else begin
      valid_d = (seen_q == 4'hF);
      if (capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel_q[i]) begin
            value_d[4*i +: 4] = dec_nibble;
            err_d[i]          = dec_invalid;
            seen_d[i]         = 1'b1;
          end
        end
      end
    end
  end

  // Input pair sampling pipeline and stability counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sel_q      <= '0;
      seg_q      <= '0;
      sel_prev_q <= '0;
      seg_prev_q <= '0;
      cnt_q      <= '0;
    end else begin
      sel_q      <= dig_sel;
      seg_q      <= seg_in;
      sel_prev_q <= sel_q;
      seg_prev_q <= seg_q;
      cnt_q      <= cnt_d;
    end
  end

  // Assembled word and handshake state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      value_q <= '0;
      err_q   <= '0;
      seen_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      value_q <= value_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      valid_q <= valid_d;
    end
  end

  assign value      = value_q;
  assign err        = err_q;
  assign out_valid  = valid_q;
  assign digit_seen = seen_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_reader
// Description : Self-checking bench for seven_segment_reader; expected words
//               are queued as digits are presented and compared on out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_reader;

  localparam int unsigned S = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  dig_sel = 4'h0;
  logic        out_ready = 1'b0;
  logic [15:0] value;
  logic [3:0]  err;
  logic        out_valid;
  logic [3:0]  digit_seen;

  int n_checks = 0;
  int n_errors = 0;
  logic [19:0] sb_q[$];   // {err, value}

  seven_segment_reader #(.STABLE_CYCLES(S)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .seg_in     (seg_in),
    .dig_sel    (dig_sel),
    .out_ready  (out_ready),
    .value      (value),
    .err        (err),
    .out_valid  (out_valid),
    .digit_seen (digit_seen)
  );

  always #5 clock = ~clock;

  // Advance n cycles; inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic present(input logic [3:0] sel, input logic [6:0] seg, input int n);
    dig_sel = sel;
    seg_in  = seg;
    tick(n);
  endtask

  // Reference decode: {invalid, nibble}
  function automatic logic [4:0] model_decode(input logic [6:0] seg);
    case (seg)
      7'h40: return 5'h00;  7'h79: return 5'h01;  7'h24: return 5'h02;  7'h30: return 5'h03;
      7'h19: return 5'h04;  7'h12: return 5'h05;  7'h02: return 5'h06;  7'h78: return 5'h07;
      7'h00: return 5'h08;  7'h18: return 5'h09;  7'h08: return 5'h0A;  7'h03: return 5'h0B;
      7'h46: return 5'h0C;  7'h21: return 5'h0D;  7'h06: return 5'h0E;  7'h0E: return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  function automatic logic [19:0] model_word(input logic [6:0] s0, input logic [6:0] s1,
                                              input logic [6:0] s2, input logic [6:0] s3);
    logic [4:0] d0, d1, d2, d3;
    d0 = model_decode(s0);
    d1 = model_decode(s1);
    d2 = model_decode(s2);
    d3 = model_decode(s3);
    return {d3[4], d2[4], d1[4], d0[4], d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    tick(2);
    n_checks++;
    if ({value, err, out_valid, digit_seen} !== 25'h0) begin
      n_errors++;
      $display("FAIL reset_state: got value=%h err=%b valid=%b seen=%b, want all zero",
               value, err, out_valid, digit_seen);
    end
    resetn = 1'b1;
    tick(3);
    n_checks++;
    if ({out_valid, digit_seen} !== 5'h0) begin
      n_errors++;
      $display("FAIL idle_after_reset: got valid=%b seen=%b, want 0/0000", out_valid, digit_seen);
    end
  endtask

  task automatic test_basic_word();
    logic [19:0] exp;
    sb_q.push_back(model_word(7'h12, 7'h78, 7'h03, 7'h0E));
    present(4'b0001, 7'h12, 6);
    present(4'b0010, 7'h78, 6);
    present(4'b0100, 7'h03, 6);
    present(4'b1000, 7'h0E, 5);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL latency_early: out_valid=%b one cycle before minimum latency, want 0", out_valid);
    end
    tick(1);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL latency_exact: out_valid=%b at STABLE_CYCLES+2, want 1", out_valid);
    end
    present(4'b0000, 7'h7F, 5);
    n_checks++;
    if (out_valid !== 1'b1 || value !== 16'hFB75 || err !== 4'h0) begin
      n_errors++;
      $display("FAIL basic_hold: got valid=%b value=%h err=%b, want 1/FB75/0000", out_valid, value, err);
    end
    exp = sb_q.pop_front();
    n_checks++;
    if ({err, value} !== exp) begin
      n_errors++;
      $display("FAIL basic_word: got %h, want %h", {err, value}, exp);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || digit_seen !== 4'h0 || value !== 16'hFB75) begin
      n_errors++;
      $display("FAIL basic_handshake: got valid=%b seen=%b value=%h, want 0/0000/FB75",
               out_valid, digit_seen, value);
    end
  endtask

  task automatic test_dwell_boundary();
    logic [19:0] exp;
    bit ok;
    out_ready = 1'b1;   // ready without a pending word must do nothing
    present(4'b0001, 7'h79, S - 1);
    present(4'b0000, 7'h7F, 6);
    n_checks++;
    if (digit_seen !== 4'h0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL short_dwell: got seen=%b valid=%b, want 0000/0", digit_seen, out_valid);
    end
    present(4'b0001, 7'h79, S);
    present(4'b0000, 7'h7F, 6);
    n_checks++;
    if (digit_seen !== 4'b0001 || value[3:0] !== 4'h1 || err[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL exact_dwell: got seen=%b nib0=%h err0=%b, want 0001/1/0",
               digit_seen, value[3:0], err[0]);
    end
    out_ready = 1'b0;
    sb_q.push_back(model_word(7'h79, 7'h24, 7'h30, 7'h19));
    present(4'b0010, 7'h24, 6);
    present(4'b0100, 7'h30, 6);
    present(4'b1000, 7'h19, 6);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      tick(1);
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL dwell_word_timeout: out_valid=%b, want 1 within budget", out_valid);
    end
    exp = sb_q.pop_front();
    n_checks++;
    if ({err, value} !== exp) begin
      n_errors++;
      $display("FAIL dwell_word: got %h, want %h", {err, value}, exp);
    end
    dig_sel   = 4'b0000;
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(2);
  endtask

  task automatic test_blank_digit();
    logic [19:0] exp;
    sb_q.push_back(model_word(7'h40, 7'h02, 7'h7F, 7'h21));
    present(4'b0001, 7'h40, 6);
    present(4'b0010, 7'h02, 6);
    present(4'b0100, 7'h7F, 6);
    present(4'b1000, 7'h21, 6);
    n_checks++;
    if (out_valid !== 1'b1 || err !== 4'b0100 || value[11:8] !== 4'h0) begin
      n_errors++;
      $display("FAIL blank_digit: got valid=%b err=%b nib2=%h, want 1/0100/0", out_valid, err, value[11:8]);
    end
    exp = sb_q.pop_front();
    n_checks++;
    if ({err, value} !== exp) begin
      n_errors++;
      $display("FAIL blank_word: got %h, want %h", {err, value}, exp);
    end
    dig_sel   = 4'b0000;
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(2);
  endtask

  task automatic test_multi_sel_and_hold();
    logic [19:0] exp;
    present(4'b0011, 7'h40, 20);
    n_checks++;
    if (digit_seen !== 4'h0) begin
      n_errors++;
      $display("FAIL multi_sel: got seen=%b, want 0000", digit_seen);
    end
    exp = model_word(7'h08, 7'h03, 7'h46, 7'h06);
    sb_q.push_back(exp);
    present(4'b0001, 7'h08, 6);
    present(4'b0010, 7'h03, 6);
    present(4'b0100, 7'h46, 6);
    present(4'b1000, 7'h06, 6);
    // A fresh dwell while the word is pending must not disturb it
    present(4'b0001, 7'h00, 8);
    n_checks++;
    if (out_valid !== 1'b1 || digit_seen !== 4'hF) begin
      n_errors++;
      $display("FAIL pending_hold: got valid=%b seen=%b, want 1/1111", out_valid, digit_seen);
    end
    exp = sb_q.pop_front();
    n_checks++;
    if ({err, value} !== exp) begin
      n_errors++;
      $display("FAIL pending_word: got %h, want %h", {err, value}, exp);
    end
    // Capture lands on the handshake edge and must be dropped
    present(4'b0000, 7'h7F, 2);
    present(4'b0010, 7'h18, 4);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    present(4'b0000, 7'h7F, 6);
    n_checks++;
    if (out_valid !== 1'b0 || digit_seen !== 4'h0 || value !== 16'hECBA) begin
      n_errors++;
      $display("FAIL handshake_drop: got valid=%b seen=%b value=%h, want 0/0000/ECBA",
               out_valid, digit_seen, value);
    end
  endtask

  task automatic test_reset_midword();
    logic [19:0] exp;
    present(4'b0001, 7'h79, 6);
    present(4'b0010, 7'h79, 6);
    present(4'b0100, 7'h79, 6);
    present(4'b1000, 7'h40, 2);
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({value, err, out_valid, digit_seen} !== 25'h0) begin
      n_errors++;
      $display("FAIL async_reset: got value=%h err=%b valid=%b seen=%b, want all zero",
               value, err, out_valid, digit_seen);
    end
    tick(1);
    resetn = 1'b1;
    present(4'b1000, 7'h78, S + 2);
    n_checks++;
    if (digit_seen !== 4'b1000 || out_valid !== 1'b0 || value !== 16'h7000 || err !== 4'h0) begin
      n_errors++;
      $display("FAIL post_reset_digit: got seen=%b valid=%b value=%h err=%b, want 1000/0/7000/0000",
               digit_seen, out_valid, value, err);
    end
    sb_q.push_back(model_word(7'h79, 7'h24, 7'h30, 7'h78));
    present(4'b0001, 7'h79, 6);
    present(4'b0010, 7'h24, 6);
    present(4'b0100, 7'h30, 6);
    exp = sb_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || {err, value} !== exp) begin
      n_errors++;
      $display("FAIL post_reset_word: got valid=%b word=%h, want 1/%h", out_valid, {err, value}, exp);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0]  pats [17];
    logic [6:0]  s [4];
    logic [19:0] exp;
    bit ok;
    pats = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00,
             7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h7F};
    for (int w = 0; w < 3; w++) begin
      for (int d = 0; d < 4; d++) s[d] = pats[$urandom_range(0, 16)];
      sb_q.push_back(model_word(s[0], s[1], s[2], s[3]));
      for (int d = 3; d >= 0; d--) present(4'(1 << d), s[d], 6);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid) begin ok = 1'b1; break; end
        tick(1);
      end
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL b2b_timeout word %0d: out_valid=%b, want 1", w, out_valid);
      end
      exp = sb_q.pop_front();
      n_checks++;
      if ({err, value} !== exp) begin
        n_errors++;
        $display("FAIL b2b_word %0d: got %h, want %h", w, {err, value}, exp);
      end
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || digit_seen !== 4'h0) begin
        n_errors++;
        $display("FAIL b2b_release %0d: got valid=%b seen=%b, want 0/0000", w, out_valid, digit_seen);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_dwell_boundary();
    test_blank_digit();
    test_multi_sel_and_hold();
    test_reset_midword();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
